// File: rtl/ifetch_if_id_if.sv
// Blocking I-cache request/response bus between the fetch unit (master)
// and the instruction cache (slave).
interface ifetch_if_id_if;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_ready;
  logic [31:0] icache_data;

  modport master (
    output icache_req,
    output icache_addr,
    input  icache_ready,
    input  icache_data
  );

  modport slave (
    input  icache_req,
    input  icache_addr,
    output icache_ready,
    output icache_data
  );
endinterface

// File: rtl/ifetch_if_id.sv
// Instruction fetch unit with one-word skid buffer, redirect handling across
// outstanding misses, and the IF/ID pipeline register with decoded fields.
module ifetch_if_id #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ifetch_if_id_if.master        icache,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [31:0]           redirect_pc,
  output logic                  id_valid,
  output logic [31:0]           id_pc,
  output logic [31:0]           id_inst,
  output logic [4:0]            id_rs,
  output logic [4:0]            id_rt,
  output logic [4:0]            id_rd,
  output logic [15:0]           id_imm16,
  output logic                  id_ext_sel
);

  typedef enum logic [1:0] {
    ST_FETCH      = 2'd0,
    ST_BUF        = 2'd1,
    ST_FLUSH_WAIT = 2'd2
  } state_t;

  localparam logic [5:0] ZEXT_OPS [3] = '{6'h0C, 6'h0D, 6'h0E};

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] buf_reg, buf_next;
  logic [31:0] pend_pc_reg, pend_pc_next;
  logic        id_valid_reg, id_valid_next;
  logic [31:0] id_pc_reg, id_inst_reg;
  logic [4:0]  id_rs_reg, id_rt_reg, id_rd_reg;
  logic [15:0] id_imm16_reg;
  logic        id_ext_sel_reg;

  logic        ld_en;
  logic [31:0] ld_pc;
  logic [31:0] ld_inst;
  logic [2:0]  op_hit;
  logic        ld_zext;

  // Extension select is decoded from the word being loaded, not from id_inst.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_zext
      assign op_hit[gi] = (ld_inst[31:26] == ZEXT_OPS[gi]);
    end
  endgenerate
  assign ld_zext = |op_hit;

  assign icache.icache_req  = !rst_n || (state_reg == ST_FETCH) || (state_reg == ST_FLUSH_WAIT);
  assign icache.icache_addr = rst_n ? pc_reg : RESET_PC;

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    buf_next      = buf_reg;
    pend_pc_next  = pend_pc_reg;
    id_valid_next = id_valid_reg;
    ld_en         = 1'b0;
    ld_pc         = pc_reg;
    ld_inst       = icache.icache_data;
    case (state_reg)
      ST_FETCH: begin
        if (flush) begin
          id_valid_next = 1'b0;
          buf_next      = 32'h0;
          if (icache.icache_ready) begin
            pc_next = redirect_pc;
          end else begin
            // Address must stay put until the cache answers.
            pend_pc_next = redirect_pc;
            state_next   = ST_FLUSH_WAIT;
          end
        end else if (icache.icache_ready) begin
          pc_next = pc_reg + 32'd4;
          if (stall) begin
            buf_next   = icache.icache_data;
            state_next = ST_BUF;
          end else begin
            ld_en         = 1'b1;
            id_valid_next = 1'b1;
          end
        end else if (!stall) begin
          id_valid_next = 1'b0;
        end
      end
      ST_BUF: begin
        if (flush) begin
          id_valid_next = 1'b0;
          buf_next      = 32'h0;
          pc_next       = redirect_pc;
          state_next    = ST_FETCH;
        end else if (!stall) begin
          ld_en         = 1'b1;
          ld_pc         = pc_reg - 32'd4;
          ld_inst       = buf_reg;
          id_valid_next = 1'b1;
          state_next    = ST_FETCH;
        end
      end
      ST_FLUSH_WAIT: begin
        if (flush) begin
          id_valid_next = 1'b0;
          buf_next      = 32'h0;
          if (icache.icache_ready) begin
            pc_next    = redirect_pc;
            state_next = ST_FETCH;
          end else begin
            pend_pc_next = redirect_pc;
          end
        end else if (icache.icache_ready) begin
          pc_next    = pend_pc_reg;
          state_next = ST_FETCH;
        end
      end
      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_FETCH;
      pc_reg         <= RESET_PC;
      buf_reg        <= 32'h0;
      pend_pc_reg    <= 32'h0;
      id_valid_reg   <= 1'b0;
      id_pc_reg      <= 32'h0;
      id_inst_reg    <= 32'h0;
      id_rs_reg      <= 5'h0;
      id_rt_reg      <= 5'h0;
      id_rd_reg      <= 5'h0;
      id_imm16_reg   <= 16'h0;
      id_ext_sel_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      buf_reg      <= buf_next;
      pend_pc_reg  <= pend_pc_next;
      id_valid_reg <= id_valid_next;
      if (ld_en) begin
        id_pc_reg      <= ld_pc;
        id_inst_reg    <= ld_inst;
        id_rs_reg      <= ld_inst[25:21];
        id_rt_reg      <= ld_inst[20:16];
        id_rd_reg      <= ld_inst[15:11];
        id_imm16_reg   <= ld_inst[15:0];
        id_ext_sel_reg <= ld_zext;
      end
    end
  end

  assign id_valid   = id_valid_reg;
  assign id_pc      = id_pc_reg;
  assign id_inst    = id_inst_reg;
  assign id_rs      = id_rs_reg;
  assign id_rt      = id_rt_reg;
  assign id_rd      = id_rd_reg;
  assign id_imm16   = id_imm16_reg;
  assign id_ext_sel = id_ext_sel_reg;

endmodule

// File: tb/tb_ifetch_if_id.sv
// Randomized and directed bench for ifetch_if_id: two instances (RESET_PC 0 and
// 0xFFFFFFFC) share stimulus and are compared each cycle to a transaction model.
module tb_ifetch_if_id;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        rdy;
  logic [31:0] data;

  ifetch_if_id_if bus0 ();
  ifetch_if_id_if bus1 ();

  assign bus0.icache_ready = rdy;
  assign bus0.icache_data  = data;
  assign bus1.icache_ready = rdy;
  assign bus1.icache_data  = data;

  logic [1:0]  o_req, o_valid, o_ext;
  logic [31:0] o_addr [2];
  logic [31:0] o_pc   [2];
  logic [31:0] o_inst [2];
  logic [4:0]  o_rs   [2];
  logic [4:0]  o_rt   [2];
  logic [4:0]  o_rd   [2];
  logic [15:0] o_imm  [2];

  assign o_req[0]  = bus0.icache_req;
  assign o_req[1]  = bus1.icache_req;
  assign o_addr[0] = bus0.icache_addr;
  assign o_addr[1] = bus1.icache_addr;

  ifetch_if_id #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .icache(bus0), .stall(stall), .flush(flush),
    .redirect_pc(redirect_pc), .id_valid(o_valid[0]), .id_pc(o_pc[0]),
    .id_inst(o_inst[0]), .id_rs(o_rs[0]), .id_rt(o_rt[0]), .id_rd(o_rd[0]),
    .id_imm16(o_imm[0]), .id_ext_sel(o_ext[0])
  );

  ifetch_if_id #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst_n(rst_n), .icache(bus1), .stall(stall), .flush(flush),
    .redirect_pc(redirect_pc), .id_valid(o_valid[1]), .id_pc(o_pc[1]),
    .id_inst(o_inst[1]), .id_rs(o_rs[1]), .id_rt(o_rt[1]), .id_rd(o_rd[1]),
    .id_imm16(o_imm[1]), .id_ext_sel(o_ext[1])
  );

  // Reference model: fetch pointer, an optional redirect still waiting for the
  // outstanding miss, and an optional parked {pc, word} held while ID stalls.
  localparam logic [31:0] RPC [2] = '{32'h0000_0000, 32'hFFFF_FFFC};
  logic [31:0] m_pc [2], m_pend [2], m_id_pc [2], m_id_inst [2];
  logic [31:0] m_park_pc [2], m_park_word [2];
  bit          m_pending [2], m_parked [2], m_valid [2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_pc[k] = RPC[k]; m_pend[k] = 32'h0; m_pending[k] = 1'b0;
        m_parked[k] = 1'b0; m_valid[k] = 1'b0;
        m_id_pc[k] = 32'h0; m_id_inst[k] = 32'h0;
      end else if (flush) begin
        m_valid[k] = 1'b0;
        if (m_parked[k] || rdy) begin
          m_pc[k] = redirect_pc; m_pending[k] = 1'b0;
        end else begin
          m_pend[k] = redirect_pc; m_pending[k] = 1'b1;
        end
        m_parked[k] = 1'b0;
      end else if (m_parked[k]) begin
        if (!stall) begin
          m_id_pc[k] = m_park_pc[k]; m_id_inst[k] = m_park_word[k];
          m_valid[k] = 1'b1; m_parked[k] = 1'b0;
          if (k == 0) $display("id load d0 pc=%08h inst=%08h (from skid)", m_id_pc[k], m_id_inst[k]);
        end
      end else if (m_pending[k]) begin
        if (rdy) begin
          m_pc[k] = m_pend[k]; m_pending[k] = 1'b0;
        end
      end else if (rdy) begin
        if (!stall) begin
          m_id_pc[k] = m_pc[k]; m_id_inst[k] = data; m_valid[k] = 1'b1;
          if (k == 0) $display("id load d0 pc=%08h inst=%08h", m_id_pc[k], m_id_inst[k]);
        end else begin
          m_park_pc[k] = m_pc[k]; m_park_word[k] = data; m_parked[k] = 1'b1;
        end
        m_pc[k] = m_pc[k] + 32'd4;
      end else if (!stall) begin
        m_valid[k] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] wi;
    logic [5:0]  op;
    logic        zext;
    for (int k = 0; k < 2; k++) begin
      wi   = m_id_inst[k];
      op   = wi[31:26];
      zext = (op == 6'h0C) || (op == 6'h0D) || (op == 6'h0E);
      chk($sformatf("d%0d_req", k),   32'(o_req[k]),   32'(!rst_n || !m_parked[k]));
      chk($sformatf("d%0d_addr", k),  o_addr[k],      rst_n ? m_pc[k] : RPC[k]);
      chk($sformatf("d%0d_valid", k), 32'(o_valid[k]), 32'(m_valid[k]));
      chk($sformatf("d%0d_pc", k),    o_pc[k],        m_id_pc[k]);
      chk($sformatf("d%0d_inst", k),  o_inst[k],      wi);
      chk($sformatf("d%0d_rs", k),    32'(o_rs[k]),   32'(wi[25:21]));
      chk($sformatf("d%0d_rt", k),    32'(o_rt[k]),   32'(wi[20:16]));
      chk($sformatf("d%0d_rd", k),    32'(o_rd[k]),   32'(wi[15:11]));
      chk($sformatf("d%0d_imm", k),   32'(o_imm[k]),  32'(wi[15:0]));
      chk($sformatf("d%0d_ext", k),   32'(o_ext[k]),  32'(zext));
    end
  endtask

  task automatic step(input bit r, input bit rd, input bit st, input bit fl,
                      input logic [31:0] rpc, input logic [31:0] w);
    rst_n = r; rdy = rd; stall = st; flush = fl; redirect_pc = rpc; data = w;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    // Reset with a hit pending: returned data must be ignored.
    step(0, 1, 0, 0, 32'h0, 32'hDEAD_BEEF);
    step(0, 1, 0, 0, 32'h0, 32'hDEAD_BEEF);
    chk("tp_rst_addr0", o_addr[0], 32'h0);

    // Back-to-back hits; the second DUT wraps from 0xFFFFFFFC to 0.
    step(1, 1, 0, 0, 32'h0, 32'h3C01_1234);
    chk("tp_inst0", o_inst[0], 32'h3C01_1234);
    chk("tp_ext0", 32'(o_ext[0]), 32'h0);
    chk("tp_wrap", o_addr[1], 32'h0);
    step(1, 1, 0, 0, 32'h0, 32'h3421_8000);
    chk("tp_ext1", 32'(o_ext[0]), 32'h1);
    chk("tp_imm1", 32'(o_imm[0]), 32'h8000);
    chk("tp_addr8", o_addr[0], 32'h8);

    // Word at PC 8 returns under a 3-cycle stall.
    step(1, 1, 1, 0, 32'h0, $urandom());
    chk("tp_buf_req", 32'(o_req[0]), 32'h0);
    step(1, 1, 1, 0, 32'h0, $urandom());
    step(1, 1, 1, 0, 32'h0, $urandom());
    step(1, 0, 0, 0, 32'h0, $urandom());
    chk("tp_skid_pc", o_pc[0], 32'h8);
    chk("tp_skid_addr", o_addr[0], 32'hC);

    // One miss round of 4 cycles on 0xC.
    for (int i = 0; i < 4; i++) step(1, (i == 3), 0, 0, 32'h0, $urandom());

    // Flush during a miss on 0x10, then a double flush where the newest wins.
    step(1, 0, 0, 0, 32'h0, $urandom());
    step(1, 0, 0, 1, 32'h100, $urandom());
    chk("tp_fw_hold", o_addr[0], 32'h10);
    step(1, 0, 0, 0, 32'h0, $urandom());
    step(1, 1, 0, 0, 32'h0, 32'hBAD0_0010);
    chk("tp_redir1", o_addr[0], 32'h100);
    step(1, 0, 0, 0, 32'h0, $urandom());
    step(1, 0, 0, 1, 32'h100, $urandom());
    step(1, 0, 0, 1, 32'h200, $urandom());
    step(1, 1, 0, 0, 32'h0, 32'hBAD0_0100);
    chk("tp_redir2", o_addr[0], 32'h200);

    // Enter BUF, then flush and stall together.
    step(1, 1, 1, 0, 32'h0, $urandom());
    step(1, 0, 1, 1, 32'h300, $urandom());
    chk("tp_fs_valid", 32'(o_valid[0]), 32'h0);
    chk("tp_fs_addr", o_addr[0], 32'h300);

    // Reset in the middle of a miss.
    step(1, 0, 0, 0, 32'h0, $urandom());
    step(0, 0, 0, 0, 32'h0, $urandom());
    chk("tp_rst_addr1", o_addr[1], 32'hFFFF_FFFC);
    chk("tp_rst_inst1", o_inst[1], 32'h0);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 99) >= 2),
           ($urandom_range(0, 99) < 55),
           ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 8),
           $urandom() & 32'hFFFF_FFFC,
           $urandom());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
